// File: rtl/axi4_rdonly_slave_mem_pkg.sv
// Shared AXI definitions: burst and response encodings, read-slave FSM
// states and a WRAP length legality helper.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } rd_state_e;

  // WRAP bursts may only be 2, 4, 8 or 16 beats long.
  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_rdonly_slave_mem_burst_addr_gen.sv
// Combinational AXI burst address stepper: given the current beat address
// and the burst attributes, produce the next beat address and flag whether
// the length is legal for a WRAP burst.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr,
  output logic                  o_wrap_legal
);

  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [ADDR_WIDTH-1:0] w_stepped;

  assign w_bytes     = ADDR_WIDTH'(1) << i_size;
  assign w_aligned   = i_addr & ~(w_bytes - ADDR_WIDTH'(1));
  assign w_stepped   = w_aligned + w_bytes;
  // Wrap window is (len+1) beats of 2^size bytes; only meaningful for legal lengths.
  assign w_wrap_mask = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);

  assign o_wrap_legal = wrap_len_legal(i_len);

  // Select the next address according to the burst type.
  always_comb begin
    o_next_addr = w_stepped;
    case (burst_e'(i_burst))
      BURST_FIXED: o_next_addr = i_addr;
      BURST_WRAP:  o_next_addr = (w_aligned & ~w_wrap_mask) | (w_stepped & w_wrap_mask);
      default:     o_next_addr = w_stepped;
    endcase
  end

endmodule

// File: rtl/axi4_rdonly_slave_mem.sv
// AXI4 read-only slave backed by a word-addressed memory with a backdoor
// write port for preloading. One outstanding burst; beat 0 appears one
// cycle after the AR handshake, then one beat per R handshake.
module axi4_rdonly_slave_mem
  import axi_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_araddr,
  input  logic [7:0]                   S_AXI_arlen,
  input  logic [2:0]                   S_AXI_arsize,
  input  logic [1:0]                   S_AXI_arburst,
  input  logic [1:0]                   S_AXI_arlock,
  input  logic [3:0]                   S_AXI_arcache,
  input  logic [2:0]                   S_AXI_arprot,
  input  logic [3:0]                   S_AXI_arregion,
  input  logic [3:0]                   S_AXI_arqos,
  input  logic                         S_AXI_arvalid,
  output logic                         S_AXI_arready,
  output logic [DATA_WIDTH-1:0]        S_AXI_rdata,
  output logic [1:0]                   S_AXI_rresp,
  output logic                         S_AXI_rlast,
  output logic                         S_AXI_rvalid,
  input  logic                         S_AXI_rready,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata
);

  localparam int unsigned     BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int unsigned     IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * (DATA_WIDTH / 8));

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  rd_state_e             r_state, w_state_nxt;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err_all;
  logic [7:0]            r_beat;

  logic                  w_ar_hs, w_r_hs, w_advance, w_done, w_load;
  logic                  w_idle;
  logic [ADDR_WIDTH-1:0] w_gen_addr, w_next_addr, w_load_addr, w_off;
  logic [7:0]            w_gen_len;
  logic [2:0]            w_gen_size;
  logic [1:0]            w_gen_burst;
  logic                  w_wrap_legal, w_ar_err, w_load_err_all, w_in_range, w_load_err;
  logic                  w_load_last;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_unused;

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ar_hs     = 1'b0;
    w_r_hs      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ar_hs = S_AXI_arvalid && r_arready;
        if (w_ar_hs) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        w_r_hs = r_rvalid && S_AXI_rready;
        if (w_r_hs && r_rlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_idle    = (r_state == ST_IDLE);
  assign w_advance = w_r_hs && !r_rlast;
  assign w_done    = w_r_hs && r_rlast;
  assign w_load    = w_ar_hs || w_advance;

  // One stepper serves both phases: in IDLE it sees the incoming AR (only its
  // WRAP-legality output matters), in BURST it steps the captured address.
  assign w_gen_addr  = w_idle ? S_AXI_araddr  : r_addr;
  assign w_gen_len   = w_idle ? S_AXI_arlen   : r_len;
  assign w_gen_size  = w_idle ? S_AXI_arsize  : r_size;
  assign w_gen_burst = w_idle ? S_AXI_arburst : r_burst;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .i_addr       (w_gen_addr),
    .i_len        (w_gen_len),
    .i_size       (w_gen_size),
    .i_burst      (w_gen_burst),
    .o_next_addr  (w_next_addr),
    .o_wrap_legal (w_wrap_legal)
  );

  assign w_ar_err = (S_AXI_arsize > 3'(BYTE_SHIFT)) ||
                    (S_AXI_arburst == BURST_RSVD) ||
                    ((S_AXI_arburst == BURST_WRAP) && !w_wrap_legal);

  // Address, error and last flag of the beat being loaded this cycle.
  assign w_load_addr    = w_idle ? S_AXI_araddr : w_next_addr;
  assign w_load_err_all = w_idle ? w_ar_err : r_err_all;
  assign w_off          = w_load_addr - BASE_ADDR;
  assign w_in_range     = (w_load_addr >= BASE_ADDR) && ({1'b0, w_off} < MEM_BYTES);
  assign w_load_err     = w_load_err_all || !w_in_range;
  assign w_idx          = w_off[IDX_W+BYTE_SHIFT-1:BYTE_SHIFT];
  assign w_load_last    = w_idle ? (S_AXI_arlen == 8'd0) : ((r_beat + 8'd1) == r_len);

  // Lock, cache, protection, region and QoS carry no meaning for this memory.
  assign w_unused = ^{S_AXI_arlock, S_AXI_arcache, S_AXI_arprot, S_AXI_arregion,
                      S_AXI_arqos, w_off};

  // Backdoor preload port; contents are never reset.
  always_ff @(posedge ACLK) begin
    if (mem_we) r_mem[mem_waddr] <= mem_wdata;
  end

  // FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Burst context capture and R channel beat registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_err_all <= 1'b0;
      r_beat    <= '0;
    end else begin
      r_arready <= (w_state_nxt == ST_IDLE);
      if (w_ar_hs) begin
        r_addr    <= S_AXI_araddr;
        r_len     <= S_AXI_arlen;
        r_size    <= S_AXI_arsize;
        r_burst   <= S_AXI_arburst;
        r_err_all <= w_ar_err;
        r_beat    <= '0;
      end else if (w_advance) begin
        r_addr <= w_next_addr;
        r_beat <= r_beat + 8'd1;
      end
      if (w_load) begin
        r_rvalid <= 1'b1;
        r_rlast  <= w_load_last;
        r_rresp  <= w_load_err ? RESP_SLVERR : RESP_OKAY;
        r_rdata  <= w_load_err ? '0 : r_mem[w_idx];
      end else if (w_done) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  assign S_AXI_arready = r_arready;
  assign S_AXI_rvalid  = r_rvalid;
  assign S_AXI_rlast   = r_rlast;
  assign S_AXI_rresp   = r_rresp;
  assign S_AXI_rdata   = r_rdata;

endmodule

// File: tb/tb_axi4_rdonly_slave_mem.sv
// Directed bench for axi4_rdonly_slave_mem: INCR/WRAP/FIXED bursts, stalls,
// out-of-range and illegal-request errors, backdoor read-before-write,
// AR held while busy, and reset in the middle of a burst.
module tb_axi4_rdonly_slave_mem;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_data [16];
  logic [1:0]  obs_resp [16];
  logic        obs_last [16];
  int          obs_gaps;
  logic        obs_rvalid_after;
  logic        obs_arready_after;

  always #5 clk = ~clk;

  axi4_rdonly_slave_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (1024),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .ACLK           (clk),
    .ARESETN        (aresetn),
    .S_AXI_araddr   (araddr),
    .S_AXI_arlen    (arlen),
    .S_AXI_arsize   (arsize),
    .S_AXI_arburst  (arburst),
    .S_AXI_arlock   (arlock),
    .S_AXI_arcache  (4'h0),
    .S_AXI_arprot   (3'h0),
    .S_AXI_arregion (4'h0),
    .S_AXI_arqos    (4'h0),
    .S_AXI_arvalid  (arvalid),
    .S_AXI_arready  (arready),
    .S_AXI_rdata    (rdata),
    .S_AXI_rresp    (rresp),
    .S_AXI_rlast    (rlast),
    .S_AXI_rvalid   (rvalid),
    .S_AXI_rready   (rready),
    .mem_we         (mem_we),
    .mem_waddr      (mem_waddr),
    .mem_wdata      (mem_wdata)
  );

  // Present an AR request and return #1 after the handshake edge.
  task automatic do_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst, input logic [1:0] lock);
    int t;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arlock = lock;
    arvalid = 1'b1;
    t = 0;
    while (arready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (arready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arready=%b required 1", arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // Accept n beats with rready held high, recording each beat.
  task automatic recv_burst(input int n);
    int t;
    obs_gaps = 0;
    rready = 1'b1;
    for (int b = 0; b < n; b++) begin
      t = 0;
      while (rvalid !== 1'b1 && t < 20) begin
        @(posedge clk); #1; t++; obs_gaps++;
      end
      if (rvalid !== 1'b1) begin
        checks++; errors++;
        $display("FAIL r_timeout: beat %0d rvalid=%b required 1", b, rvalid);
        rready = 1'b0;
        return;
      end
      obs_data[b] = rdata; obs_resp[b] = rresp; obs_last[b] = rlast;
      @(posedge clk); #1;
    end
    obs_rvalid_after  = rvalid;
    obs_arready_after = arready;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL reset_arready: got %b exp 0", arready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b exp 0", rvalid); end
    checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast: got %b exp 0", rlast); end
    checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp: got %b exp 00", rresp); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", rdata); end
    aresetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_release_arready: got %b exp 1", arready); end
  endtask

  task automatic test_incr();
    logic [31:0] exp_d;
    logic        exp_l;
    do_ar(32'h10, 8'd3, 3'd2, 2'b01, 2'b01);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL incr_latency: rvalid=%b exp 1", rvalid); end
    recv_burst(4);
    for (int b = 0; b < 4; b++) begin
      exp_d = 32'hA000_0004 + 32'(b);
      exp_l = (b == 3);
      checks++; if (obs_data[b] !== exp_d) begin errors++; $display("FAIL incr_data[%0d]: got %h exp %h", b, obs_data[b], exp_d); end
      checks++; if (obs_resp[b] !== 2'b00) begin errors++; $display("FAIL incr_resp[%0d]: got %b exp 00", b, obs_resp[b]); end
      checks++; if (obs_last[b] !== exp_l) begin errors++; $display("FAIL incr_last[%0d]: got %b exp %b", b, obs_last[b], exp_l); end
    end
    checks++; if (obs_gaps !== 0) begin errors++; $display("FAIL incr_gaps: got %0d exp 0", obs_gaps); end
    checks++; if (obs_rvalid_after !== 1'b0) begin errors++; $display("FAIL incr_rvalid_after: got %b exp 0", obs_rvalid_after); end
    checks++; if (obs_arready_after !== 1'b1) begin errors++; $display("FAIL incr_arready_after: got %b exp 1", obs_arready_after); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [4];
    logic [31:0] exp_d;
    logic        exp_l;
    exp_w = '{32'h0E, 32'h0F, 32'h0C, 32'h0D};
    do_ar(32'h38, 8'd3, 3'd2, 2'b10, 2'b00);
    recv_burst(4);
    for (int b = 0; b < 4; b++) begin
      exp_d = 32'hA000_0000 + exp_w[b];
      exp_l = (b == 3);
      checks++; if (obs_data[b] !== exp_d) begin errors++; $display("FAIL wrap_data[%0d]: got %h exp %h", b, obs_data[b], exp_d); end
      checks++; if (obs_last[b] !== exp_l) begin errors++; $display("FAIL wrap_last[%0d]: got %b exp %b", b, obs_last[b], exp_l); end
    end
  endtask

  task automatic test_fixed_stall();
    do_ar(32'h8, 8'd2, 3'd2, 2'b00, 2'b00);
    checks++; if (rdata !== 32'hA000_0002) begin errors++; $display("FAIL fixed_beat0: got %h exp a0000002", rdata); end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL fixed_stall_rvalid[%0d]: got %b exp 1", s, rvalid); end
      checks++; if (rdata !== 32'hA000_0002) begin errors++; $display("FAIL fixed_stall_rdata[%0d]: got %h exp a0000002", s, rdata); end
      checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL fixed_stall_rlast[%0d]: got %b exp 0", s, rlast); end
    end
    rready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rlast !== 1'b1 || rdata !== 32'hA000_0002) begin errors++; $display("FAIL fixed_beat2: rlast=%b rdata=%h exp 1 a0000002", rlast, rdata); end
    @(posedge clk); #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL fixed_beat_count: rvalid=%b exp 0 after 3 beats", rvalid); end
    rready = 1'b0;
  endtask

  task automatic test_oob();
    logic [31:0] exp_d [4];
    logic [1:0]  exp_r [4];
    exp_d = '{32'hA000_03FE, 32'hA000_03FF, 32'h0, 32'h0};
    exp_r = '{2'b00, 2'b00, 2'b10, 2'b10};
    do_ar(32'hFF8, 8'd3, 3'd2, 2'b01, 2'b00);
    recv_burst(4);
    for (int b = 0; b < 4; b++) begin
      checks++; if (obs_data[b] !== exp_d[b]) begin errors++; $display("FAIL oob_data[%0d]: got %h exp %h", b, obs_data[b], exp_d[b]); end
      checks++; if (obs_resp[b] !== exp_r[b]) begin errors++; $display("FAIL oob_resp[%0d]: got %b exp %b", b, obs_resp[b], exp_r[b]); end
    end
    checks++; if (obs_last[3] !== 1'b1) begin errors++; $display("FAIL oob_last: got %b exp 1", obs_last[3]); end
  endtask

  task automatic test_errs();
    logic [7:0] lens [3];
    logic [2:0] sizes [3];
    logic [1:0] bursts [3];
    int         n;
    logic       exp_l;
    lens   = '{8'd1, 8'd2, 8'd2};
    sizes  = '{3'd3, 3'd2, 3'd2};
    bursts = '{2'b01, 2'b11, 2'b10};
    for (int c = 0; c < 3; c++) begin
      n = int'(lens[c]) + 1;
      do_ar(32'h0, lens[c], sizes[c], bursts[c], 2'b00);
      recv_burst(n);
      for (int b = 0; b < n; b++) begin
        exp_l = (b == n - 1);
        checks++; if (obs_resp[b] !== 2'b10 || obs_data[b] !== 32'h0) begin errors++; $display("FAIL err_case%0d_beat%0d: resp=%b data=%h exp 10 00000000", c, b, obs_resp[b], obs_data[b]); end
        checks++; if (obs_last[b] !== exp_l) begin errors++; $display("FAIL err_case%0d_last%0d: got %b exp %b", c, b, obs_last[b], exp_l); end
      end
      checks++; if (obs_rvalid_after !== 1'b0) begin errors++; $display("FAIL err_case%0d_len: rvalid=%b exp 0", c, obs_rvalid_after); end
    end
  endtask

  task automatic test_rbw();
    do_ar(32'h40, 8'd1, 3'd2, 2'b01, 2'b00);
    rready = 1'b1;
    mem_we = 1'b1; mem_waddr = 10'h011; mem_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_we = 1'b0;
    checks++; if (rdata !== 32'hA000_0011) begin errors++; $display("FAIL rbw_old: got %h exp a0000011", rdata); end
    @(posedge clk); #1;
    rready = 1'b0;
    do_ar(32'h44, 8'd0, 3'd2, 2'b01, 2'b00);
    recv_burst(1);
    checks++; if (obs_data[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rbw_new: got %h exp deadbeef", obs_data[0]); end
    checks++; if (obs_last[0] !== 1'b1) begin errors++; $display("FAIL rbw_single_last: got %b exp 1", obs_last[0]); end
  endtask

  task automatic test_back_to_back();
    do_ar(32'h0, 8'd1, 3'd2, 2'b01, 2'b00);
    araddr = 32'h80; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    rready = 1'b1;
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL b2b_busy0: arready=%b exp 0", arready); end
    @(posedge clk); #1;
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL b2b_busy1: arready=%b exp 0", arready); end
    checks++; if (rdata !== 32'hA000_0001 || rlast !== 1'b1) begin errors++; $display("FAIL b2b_beat1: rdata=%h rlast=%b exp a0000001 1", rdata, rlast); end
    @(posedge clk); #1;
    checks++; if (arready !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle: arready=%b rvalid=%b exp 1 0", arready, rvalid); end
    @(posedge clk); #1;
    arvalid = 1'b0;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'hA000_0020 || rlast !== 1'b1) begin errors++; $display("FAIL b2b_second: rvalid=%b rdata=%h rlast=%b exp 1 a0000020 1", rvalid, rdata, rlast); end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset_midburst();
    do_ar(32'h0, 8'd7, 3'd2, 2'b01, 2'b00);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    aresetn = 1'b0;
    @(posedge clk); #1;
    checks++; if (rvalid !== 1'b0 || arready !== 1'b0 || rlast !== 1'b0) begin errors++; $display("FAIL rst_mid_abort: rvalid=%b arready=%b rlast=%b exp 0 0 0", rvalid, arready, rlast); end
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (arready !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_release: arready=%b rvalid=%b exp 1 0", arready, rvalid); end
    do_ar(32'h20, 8'd1, 3'd2, 2'b01, 2'b00);
    recv_burst(2);
    checks++; if (obs_data[0] !== 32'hA000_0008 || obs_data[1] !== 32'hA000_0009) begin errors++; $display("FAIL rst_mid_newburst: got %h %h exp a0000008 a0000009", obs_data[0], obs_data[1]); end
    checks++; if (obs_last[0] !== 1'b0 || obs_last[1] !== 1'b1) begin errors++; $display("FAIL rst_mid_newlast: got %b %b exp 0 1", obs_last[0], obs_last[1]); end
  endtask

  initial begin
    aresetn = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arvalid = 1'b0;
    rready = 1'b0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++) begin
      mem_we = 1'b1; mem_waddr = 10'(i); mem_wdata = 32'hA000_0000 + 32'(i);
      @(posedge clk); #1;
    end
    mem_we = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_stall();
    test_oob();
    test_errs();
    test_rbw();
    test_back_to_back();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_rdonly_slave_mem.md
Name: axi4_rdonly_slave_mem

Overview:
AXI4 read-only responder (slave) holding a word-addressed memory. It sits on an interconnect M0x read port and serves AR requests with R bursts. It is the endpoint counterpart of the read-only interconnect, used as the default slave model on FPGA builds and in benches. A backdoor write port preloads contents.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, R data width; must be 32 or 64
MEM_DEPTH, 1024, number of DATA_WIDTH words; power of two
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
S_AXI_araddr  in  ADDR_WIDTH  read address
S_AXI_arlen  in  8  beats minus one
S_AXI_arsize  in  3  log2 bytes per beat
S_AXI_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
S_AXI_arlock  in  2  ignored except exclusive bit [0]
S_AXI_arcache/arprot/arregion/arqos  in  4/3/4/4  accepted, ignored
S_AXI_arvalid  in  1  AR valid
S_AXI_arready  out  1  AR ready
S_AXI_rdata  out  DATA_WIDTH  read data
S_AXI_rresp  out  2  00 OKAY, 10 SLVERR
S_AXI_rlast  out  1  last beat
S_AXI_rvalid  out  1  R valid
S_AXI_rready  in  1  R ready
mem_we  in  1  backdoor write enable
mem_waddr  in  log2(MEM_DEPTH)  backdoor word index
mem_wdata  in  DATA_WIDTH  backdoor data

Behaviour:
- Reset: arready=0, rvalid=0, rlast=0, rresp=00, rdata=0, FSM=IDLE, beat counter=0. Memory contents are not reset. Reset asserted mid-burst aborts the burst at that edge with no further beats.
- FSM IDLE: arready=1 from the first cycle after reset release. On arvalid&&arready, capture addr/len/size/burst, compute the error flag, drop arready, go to BURST.
- BURST: beat 0 appears with rvalid=1 in the cycle after the AR handshake (1-cycle latency). rdata/rresp/rlast stay stable while rvalid&&!rready. On rvalid&&rready the next beat is presented in the following cycle (one beat per cycle under continuous rready).
- rlast=1 exactly on beat arlen. After the last handshake: rvalid=0, return to IDLE, arready=1 in the next cycle. There is no AR/R overlap; at most one outstanding burst.
- Address step: FIXED keeps the address. INCR adds 1<<arsize after each beat, with later beats aligned to arsize. WRAP wraps within a boundary of (arlen+1)*(1<<arsize) bytes aligned down. No 4KB check; the address wraps modulo 2^ADDR_WIDTH.
- Word index = (addr-BASE_ADDR)>>log2(DATA_WIDTH/8).
- SLVERR (rdata=0), full burst length still returned, when:
  - the byte offset is at or beyond MEM_DEPTH*DATA_WIDTH/8, or the address is below BASE_ADDR (checked per beat);
  - arsize>log2(DATA_WIDTH/8) (all beats);
  - arburst=11 (all beats);
  - WRAP with arlen not in {1,3,7,15} (all beats).
- Exclusive (arlock[0]=1) returns OKAY, never EXOKAY.
- Backdoor write: writes at the clock edge. A write to the same word in the same cycle a beat is loaded returns the old data (read-before-write).
- arvalid while busy: arready stays 0; the request must be held by the master per AXI.

Decomposition:
- Shared axi_pkg: burst encodings (FIXED/INCR/WRAP), resp codes (OKAY/EXOKAY/SLVERR/DECERR), FSM state enum.
- Sub-module axi_burst_addr_gen: combinational next-address from (addr, len, size, burst), plus a WRAP-legality output. It is reused later by the write-side slave.

Test Plan:
- Preload word i = 32'hA000_0000+i; INCR araddr=0x10, arlen=3, arsize=2, rready=1 -> rdata A0000004..A0000007 on 4 consecutive cycles, rlast on the 4th, rresp=00, first rvalid 1 cycle after handshake.
- WRAP araddr=0x38, arlen=3, arsize=2 -> words 0E,0F,0C,0D; rlast on beat 3.
- FIXED araddr=0x8, arlen=2 -> word 2 returned 3 times; toggle rready 1-0-0-1 -> rdata/rlast stable during stalls, 3 beats total.
- INCR araddr=0xFF8 (MEM_DEPTH=1024), arlen=3 -> beats 0-1 OKAY (words 3FE, 3FF), beats 2-3 SLVERR with rdata=0.
- arsize=3 on a 32-bit bus, and separately arburst=11 -> all arlen+1 beats SLVERR; WRAP arlen=2 -> SLVERR ×3.
- Deassert ARESETN during beat 1 of an arlen=7 burst -> rvalid=0 next edge; after release arready=1 one cycle later, and a new AR is served correctly.
